fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: fetch address loaded at reset.
REQ-002 Parameter PC_INC, default 16'h0001: PC increment per fetched word.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 jump_en  input  1  redirect request from execute stage.
REQ-006 jump_addr  input  16  redirect target.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  16  request address; equals pc while imem_req=1.
REQ-009 imem_gnt  input  1  request accepted when imem_req&&imem_gnt.
REQ-010 imem_rvalid  input  1  read data valid; in-order, max one outstanding.
REQ-011 imem_rdata  input  16  read data.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode accepts; pop when inst_valid&&inst_ready.
REQ-014 inst  output  16  head instruction word.
REQ-015 inst_pc  output  16  address of head instruction.
REQ-016 pc  output  16  next fetch address (architectural R6 view).

Function
REQ-017 States: START, REQ, WAIT, DROP; START lasts exactly one cycle after reset release, no request, then REQ.
REQ-018 REQ: imem_req=1 iff buffer count < DEPTH (registered count); on grant latch req_pc=pc, pc<=pc+PC_INC modulo 2^16 (16'hFFFF+1 -> 16'h0000), go WAIT.
REQ-019 WAIT: imem_req=0; on imem_rvalid push {imem_rdata, req_pc} to buffer, go REQ.
REQ-020 DROP: imem_req=0; on imem_rvalid discard data, go REQ.
REQ-021 jump_en in any state: pc<=jump_addr, buffer flushed, inst_valid=0 next cycle.
REQ-022 jump_en in REQ with grant same cycle: granted request is stale, go DROP; pc<=jump_addr (no increment).
REQ-023 jump_en in WAIT without rvalid: go DROP; with rvalid same cycle: discard data, go REQ.
REQ-024 jump_en in DROP: pc updated, remain DROP until rvalid.
REQ-025 Simultaneous pop and jump: flush wins; simultaneous push and pop: both occur, count unchanged.
REQ-026 Buffer never overflows: request issued only with free slot, one outstanding maximum.
REQ-027 Fetch-to-inst_valid latency: one cycle after imem_rvalid.

Reset
REQ-028 rst_n low: state=START, pc=RESET_PC, buffer empty, inst_valid=0, imem_req=0, inst=16'h0000, inst_pc=16'h0000, req_pc=16'h0000, immediately and asynchronously.
REQ-029 Reset mid-transaction abandons outstanding request; a late imem_rvalid arriving in START shall be ignored.

Configuration
REQ-030 Macro FETCH_BUF2_EN defined: DEPTH=2 FIFO buffer, allowing next request while one instruction waits.
REQ-031 Macro undefined: DEPTH=1 single holding register; interface identical.

Structure
REQ-032 Package fetch_pkg holds state enumeration, ADDR_W=16, INST_W=16, and DEPTH derived from FETCH_BUF2_EN.
REQ-033 Buffer implemented as sub-module inst_fifo (push, pop, flush, count, head data/pc).

Verification
REQ-034 Reset release, gnt=1, rvalid one cycle after grant, inst_ready=1 -> imem_addr 0000,0001,0002 in order; inst_pc matches each inst.
REQ-035 inst_ready=0 with DEPTH=1 -> exactly one fetch completes, imem_req stays 0 until pop.
REQ-036 jump_en with jump_addr=16'h0040 during WAIT, rvalid two cycles later -> data discarded, next imem_addr=16'h0040, no inst_valid for stale word.
REQ-037 jump_en and grant same cycle in REQ (pc=16'h0005, jump_addr=16'h0100) -> DROP, next request address 16'h0100.
REQ-038 pc=16'hFFFF granted -> pc wraps to 16'h0000, inst_pc=16'hFFFF.
REQ-039 rst_n asserted while WAIT with data pending -> outputs at reset values immediately, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   ADDR_W / INST_W : address and instruction word widths
//   DEPTH           : instruction buffer depth (2 when FETCH_BUF2_EN is defined,
//                     otherwise 1)
//   CNT_W           : width of the buffer occupancy counter
//   fetch_state_e   : fetch FSM states
//   fetch_entry_t   : one buffered instruction with its address
// Build option: FETCH_BUF2_EN selects the two-entry buffer.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; the natural 16-bit overflow gives the wrap.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] cur_pc,
                                                   input logic [ADDR_W-1:0] inc);
    return cur_pc + inc;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Small in-order instruction buffer between fetch and decode. Entry 0 is
// always the head, so the head outputs come straight from registers.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_entry_i at the tail
//   push_entry_i   : instruction word + its address
//   pop_i          : remove the head entry
//   flush_i        : discard all entries (overrides push and pop)
//   count_o        : number of valid entries
//   head_data_o    : head instruction word
//   head_pc_o      : head instruction address
// Depth follows fetch_pkg::DEPTH (FETCH_BUF2_EN build option).
// -----------------------------------------------------------------------------
module inst_fifo
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  fetch_entry_t      push_entry_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [INST_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] head_pc_o
);

  fetch_entry_t     ent_q [DEPTH];
  fetch_entry_t     ent_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_pop_s;
  logic             do_push_s;
  logic [CNT_W-1:0] wr_idx_s;

  // Next buffer contents: shift on pop, then write the tail slot on push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    count_d   = count_q;
    do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
    // A push into a full buffer is only legal when the head leaves this cycle.
    do_push_s = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop_s);
    wr_idx_s  = do_pop_s ? (count_q - CNT_W'(1)) : count_q;

    if (flush_i) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_d[i] = do_pop_s ? ent_q[i+1] : ent_q[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = (do_push_s && (CNT_W'(i) == wr_idx_s)) ? push_entry_i : ent_d[i];
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Buffer storage and occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{data: {INST_W{1'b0}}, pc: {ADDR_W{1'b0}}};
      end
      count_q <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = ent_q[0].data;
  assign head_pc_o   = ent_q[0].pc;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues one outstanding request at a time to the
// instruction memory, buffers returned words for decode, and handles
// redirects (jumps) by flushing the buffer and discarding stale responses.
// Parameters:
//   RESET_PC : fetch address after reset
//   PC_INC   : address step per fetched word
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   jump_en, jump_addr            : redirect request and target
//   imem_req, imem_addr, imem_gnt : request handshake to instruction memory
//   imem_rvalid, imem_rdata       : in-order read response
//   inst_valid, inst_ready        : handshake to decode
//   inst, inst_pc                 : head instruction and its address
//   pc                            : next fetch address
// Build option: FETCH_BUF2_EN enables a two-entry buffer so the next fetch can
// be in flight while one instruction waits for decode.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic [ADDR_W-1:0] req_pc_d;

  logic [CNT_W-1:0]  fifo_count_s;
  logic              buf_free_s;
  logic              inst_valid_s;
  logic              imem_req_s;
  logic              grant_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  fetch_entry_t      push_entry_s;

  // Occupancy is registered inside the buffer, so the request never depends
  // on this cycle's pop.
  assign buf_free_s   = (fifo_count_s < CNT_W'(DEPTH));
  assign inst_valid_s = (fifo_count_s != {CNT_W{1'b0}});

  // State, fetch address and in-flight request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_START;
      pc_q     <= RESET_PC;
      req_pc_q <= {ADDR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state logic of the fetch FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: begin
        // Any response arriving here belongs to a request abandoned by reset.
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_s) begin
          // A jump in the grant cycle makes the just-issued fetch stale.
          state_d = jump_en ? ST_DROP : ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end else if (jump_en) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // Output and datapath control of the fetch FSM.
  always_comb begin
    imem_req_s = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req_s = buf_free_s;
      end
      ST_WAIT: begin
        // A response racing a jump is stale and is dropped.
        push_s = imem_rvalid && !jump_en;
      end
      ST_START, ST_DROP: begin
        imem_req_s = 1'b0;
        push_s     = 1'b0;
      end
      default: begin
        imem_req_s = 1'b0;
        push_s     = 1'b0;
      end
    endcase

    grant_s = imem_req_s && imem_gnt;
    flush_s = jump_en;
    // Flush wins over a simultaneous pop.
    pop_s   = inst_valid_s && inst_ready && !jump_en;

    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (jump_en) begin
      pc_d = jump_addr;
    end else if (grant_s) begin
      pc_d     = pc_advance(pc_q, PC_INC);
      req_pc_d = pc_q;
    end else begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
    end
  end

  assign push_entry_s = '{data: imem_rdata, pc: req_pc_q};

  inst_fifo u_inst_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .flush_i      (flush_s),
    .count_o      (fifo_count_s),
    .head_data_o  (inst),
    .head_pc_o    (inst_pc)
  );

  assign imem_req   = imem_req_s;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_s;
  assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit in its default build (one-entry
// buffer). Each table row holds the inputs driven after a falling edge and the
// outputs expected at that moment (state from the previous rising edge).
// A short hand-written sequence then covers a fetch into a stalled decode and
// an asynchronous reset asserted in the middle of a clock phase.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] pc;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;
    logic        ready;
    logic        e_req;
    logic        e_valid;
    logic        chk_inst;
    logic [15:0] e_inst;
    logic [15:0] e_ipc;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'h0001)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string nm, input logic r, input logic j, input logic [15:0] ja,
                              input logic g, input logic rv, input logic [15:0] rd, input logic rdy,
                              input logic ereq, input logic ev, input logic ck,
                              input logic [15:0] ei, input logic [15:0] eip, input logic [15:0] ep);
    vec_t v;
    v.name = nm; v.rst_n = r; v.jump_en = j; v.jump_addr = ja; v.gnt = g; v.rvalid = rv;
    v.rdata = rd; v.ready = rdy; v.e_req = ereq; v.e_valid = ev; v.chk_inst = ck;
    v.e_inst = ei; v.e_ipc = eip; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    //                    name          rst j  jaddr     g  rv rdata     rdy  req val ck inst      ipc       pc
    vecs.push_back(mk("reset_hold",    0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0,  0,  1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("start_cycle",   1, 0, 16'h0000, 1, 1, 16'h7777, 0,   0,  0,  1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("req_0000",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("wait_0000",     1, 0, 16'h0000, 1, 1, 16'hA000, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0001));
    vecs.push_back(mk("inst_0000",     1, 0, 16'h0000, 1, 0, 16'h0000, 1,   0,  1,  1, 16'hA000, 16'h0000, 16'h0001));
    vecs.push_back(mk("req_0001",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0001));
    vecs.push_back(mk("wait_0001",     1, 0, 16'h0000, 1, 1, 16'hA001, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0002));
    vecs.push_back(mk("inst_0001",     1, 0, 16'h0000, 1, 0, 16'h0000, 1,   0,  1,  1, 16'hA001, 16'h0001, 16'h0002));
    vecs.push_back(mk("req_0002",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0002));
    vecs.push_back(mk("wait_0002",     1, 0, 16'h0000, 1, 1, 16'hA002, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0003));
    vecs.push_back(mk("stall_a",       1, 0, 16'h0000, 1, 0, 16'h0000, 0,   0,  1,  1, 16'hA002, 16'h0002, 16'h0003));
    vecs.push_back(mk("stall_b",       1, 0, 16'h0000, 1, 0, 16'h0000, 0,   0,  1,  1, 16'hA002, 16'h0002, 16'h0003));
    vecs.push_back(mk("stall_c",       1, 0, 16'h0000, 1, 0, 16'h0000, 0,   0,  1,  1, 16'hA002, 16'h0002, 16'h0003));
    vecs.push_back(mk("stall_pop",     1, 0, 16'h0000, 0, 0, 16'h0000, 1,   0,  1,  1, 16'hA002, 16'h0002, 16'h0003));
    vecs.push_back(mk("req_no_gnt",    1, 0, 16'h0000, 0, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0003));
    vecs.push_back(mk("jump_in_req",   1, 1, 16'h0005, 0, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0003));
    vecs.push_back(mk("jump_and_gnt",  1, 1, 16'h0100, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0005));
    vecs.push_back(mk("drop_idle",     1, 0, 16'h0000, 1, 0, 16'h0000, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0100));
    vecs.push_back(mk("drop_rvalid",   1, 0, 16'h0000, 1, 1, 16'hDEAD, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0100));
    vecs.push_back(mk("req_0100",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0100));
    vecs.push_back(mk("jump_in_wait",  1, 1, 16'h0040, 0, 0, 16'h0000, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0101));
    vecs.push_back(mk("drop_wait1",    1, 0, 16'h0000, 0, 0, 16'h0000, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0040));
    vecs.push_back(mk("drop_stale",    1, 0, 16'h0000, 0, 1, 16'hBEEF, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0040));
    vecs.push_back(mk("req_0040",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0040));
    vecs.push_back(mk("jump_rvalid",   1, 1, 16'hFFFF, 0, 1, 16'h1234, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0041));
    vecs.push_back(mk("req_ffff",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'hFFFF));
    vecs.push_back(mk("wait_wrap",     1, 0, 16'h0000, 0, 1, 16'h5678, 1,   0,  0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("pop_and_jump",  1, 1, 16'h0200, 0, 0, 16'h0000, 1,   0,  1,  1, 16'h5678, 16'hFFFF, 16'h0000));
    vecs.push_back(mk("req_0200",      1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0200));
    vecs.push_back(mk("reset_in_wait", 0, 0, 16'h0000, 0, 0, 16'h0000, 1,   0,  0,  1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("reset_rvalid",  0, 0, 16'h0000, 0, 1, 16'h9999, 1,   0,  0,  1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("start_late_rv", 1, 0, 16'h0000, 1, 1, 16'h9999, 1,   0,  0,  1, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("post_rst_req",  1, 0, 16'h0000, 0, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("post_rst_idle", 1, 0, 16'h0000, 0, 0, 16'h0000, 1,   1,  0,  0, 16'h0000, 16'h0000, 16'h0000));

    rst_n       = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = 16'h0000;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    inst_ready  = 1'b0;
    #1 rst_n    = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      logic ok;
      @(negedge clk);
      rst_n       = vecs[i].rst_n;
      jump_en     = vecs[i].jump_en;
      jump_addr   = vecs[i].jump_addr;
      imem_gnt    = vecs[i].gnt;
      imem_rvalid = vecs[i].rvalid;
      imem_rdata  = vecs[i].rdata;
      inst_ready  = vecs[i].ready;
      #1;
      ok = (imem_req === vecs[i].e_req) && (inst_valid === vecs[i].e_valid) &&
           (pc === vecs[i].e_pc) && (!vecs[i].e_req || (imem_addr === vecs[i].e_pc)) &&
           (!vecs[i].chk_inst || ((inst === vecs[i].e_inst) && (inst_pc === vecs[i].e_ipc)));
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL vec%0d %s: got req=%b addr=%h valid=%b inst=%h inst_pc=%h pc=%h, expected req=%b valid=%b inst=%h inst_pc=%h pc=%h (inst checked=%b)",
                 i, vecs[i].name, imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
                 vecs[i].e_req, vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_pc, vecs[i].chk_inst);
      end
    end

    // Fetch one word into a stalled decode, then reset mid clock-high phase.
    @(negedge clk);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    #1;
    chk("seq_req_issued", {15'h0000, imem_req}, 16'h0001);
    chk("seq_req_addr", imem_addr, 16'h0000);
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hCAFE;
    #1;
    chk("seq_wait_pc", pc, 16'h0001);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("seq_valid", {15'h0000, inst_valid}, 16'h0001);
    chk("seq_inst", inst, 16'hCAFE);
    chk("seq_inst_pc", inst_pc, 16'h0000);
    chk("seq_full_no_req", {15'h0000, imem_req}, 16'h0000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'h0000, inst_valid}, 16'h0000);
    chk("async_rst_inst", inst, 16'h0000);
    chk("async_rst_inst_pc", inst_pc, 16'h0000);
    chk("async_rst_pc", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
